muldiv_seq_unit: RTL and testbench
==================================

// Module: muldiv_seq_unit
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit with HI/LO registers, in the E stage.
//  Successor to the fixed 32-bit mult/div block:
//   - width and latencies are parameters;
//   - adds madd/maddu/msub/msubu accumulate ops;
//   - defines divide-by-zero and signed-overflow results;
//   - adds a one-cycle done pulse.
//  The stall controller uses busy/tnew. The CP0 exception request (flush) suppresses issue.
// PARAMETERS
//  WIDTH    32  operand, HI and LO width
//  MUL_LAT  5   cycles from accepted mult/madd/msub issue to HI/LO update (>=1)
//  DIV_LAT  10  cycles from accepted div/divu issue to HI/LO update (>=1)
//  (localparam CNT_W = $clog2(max(MUL_LAT,DIV_LAT)+1))
// PORTS
//  clk     in   1      clock, rising edge
//  reset   in   1      synchronous, active-high
//  start   in   1      issue request; op/src_a/src_b valid while high
//  op      in   4      0 nop, 1 mult, 2 multu, 3 div, 4 divu, 5 madd, 6 maddu,
//                      7 msub, 8 msubu, 9 mthi, 10 mtlo; 11-15 = nop
//  src_a   in   WIDTH  rs value (dividend / multiplicand / mthi-mtlo data)
//  src_b   in   WIDTH  rt value (divisor / multiplier)
//  flush   in   1      exception request; suppresses issue this cycle
//  busy    out  1      arithmetic op in flight
//  done    out  1      1-cycle pulse in the cycle after HI/LO are updated
//  tnew    out  CNT_W  cycles remaining until HI/LO valid; 0 when idle
//  hi      out  WIDTH  HI register
//  lo      out  WIDTH  LO register
// BEHAVIOUR
//  Reset (synchronous, highest priority, also mid-operation):
//   - hi, lo, busy, done and tnew go to 0; state goes to IDLE.
//   - Latched operands and opcode are cleared; the in-flight op is discarded.
//  Issue acceptance:
//   - A request is accepted at an edge only when start=1, flush=0 and busy=0.
//   - start while busy=1 is ignored; the controller must stall.
//   - start with flush=1 has no effect, including mthi/mtlo.
//   - flush never aborts an op already in flight.
//  mthi/mtlo:
//   - On acceptance, hi or lo <= src_a at that edge.
//   - No busy, no done, tnew stays 0.
//  Arithmetic ops, FSM IDLE -> BUSY -> IDLE:
//   - Acceptance edge t0: latch src_a, src_b and op; LAT = MUL_LAT or DIV_LAT.
//     busy<=1, tnew<=LAT.
//   - Each following edge in BUSY: tnew decrements.
//   - Edge t0+LAT: hi/lo written, busy<=0, tnew<=0, done<=1, state IDLE.
//   - busy is therefore high for exactly LAT cycles.
//   - done is cleared at the next edge.
//   - A new start may be accepted in the cycle done is high.
//  Arithmetic rules (2*WIDTH-bit product P):
//   - mult/multu: {hi,lo} = P, signed/unsigned.
//   - madd*: {hi,lo} = {hi,lo} + P.  msub*: {hi,lo} = {hi,lo} - P.
//   - Accumulate uses hi/lo at the completion edge, modulo 2^(2*WIDTH).
//   - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
//   - divu: unsigned quotient and remainder.
//   - Divisor 0: hi/lo unchanged; full latency, busy and done still occur.
//   - div MIN/-1 (src_a = 1<<(WIDTH-1), src_b = all ones): lo = MIN, hi = 0.
//  Outputs hi, lo, busy, done and tnew are registered; no combinational path from inputs.
// TESTING
//  1. mult src_a=FFFFFFFD src_b=5 -> busy 5 cycles, tnew 5,4,3,2,1,0;
//     hi=FFFFFFFF lo=FFFFFFF1; done for 1 cycle.
//  2. divu 7,2 -> after 10 cycles lo=3 hi=1.
//     div FFFFFFF9,2 -> lo=FFFFFFFD hi=FFFFFFFF.
//  3. div by 0 with hi=AAAA lo=5555 -> hi/lo unchanged after 10 cycles, done pulses.
//     div 80000000,FFFFFFFF -> lo=80000000 hi=0.
//  4. mthi 1, mtlo FFFFFFFF, then maddu 1,1 -> hi=2 lo=0.
//     Then msub 1,2 -> hi=1 lo=FFFFFFFE.
//  5. Issue mult; at cycle 2 assert start(mtlo 1234) -> ignored, lo=mult result.
//     start+flush with mult -> busy stays 0.
//     flush during busy -> result still written.
//  6. reset at cycle 3 of div -> next cycle busy=0, tnew=0, hi=lo=0, no done pulse.

Source files
------------

// File: rtl/muldiv_seq_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and accumulate ops.
// Results are committed after a fixed latency; busy/tnew let the stall logic hold dependents.
module muldiv_seq_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10,
  localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT,
  localparam int unsigned CNT_W  = $clog2(MaxLat + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] tnew_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [CNT_W-1:0] MulLatC = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DivLatC = CNT_W'(DIV_LAT);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       op_q, op_d;

  logic                 accept;
  logic                 is_signed;
  logic [2*WIDTH-1:0]   acc, ext_a, ext_b, prod, result;
  logic                 neg_a, neg_b;
  logic [WIDTH-1:0]     mag_a, mag_b, div_b, q_mag, r_mag, quot, rem;

  assign accept = start_i && !flush_i && (state_q == ST_IDLE);

  // Datapath evaluates the latched operands; only the completion edge consumes it.
  always_comb begin
    is_signed = (op_q == OP_MULT) || (op_q == OP_DIV) || (op_q == OP_MADD) ||
                (op_q == OP_MSUB);
    acc   = {hi_q, lo_q};
    ext_a = is_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b = is_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod  = ext_a * ext_b;

    // Sign-magnitude division: truncation toward zero falls out naturally, and
    // MIN / -1 yields magnitude 2^(WIDTH-1), which reads back as MIN.
    neg_a = is_signed && a_q[WIDTH-1];
    neg_b = is_signed && b_q[WIDTH-1];
    mag_a = neg_a ? -a_q : a_q;
    mag_b = neg_b ? -b_q : b_q;
    div_b = (b_q == '0) ? WIDTH'(1) : mag_b;
    q_mag = mag_a / div_b;
    r_mag = mag_a % div_b;
    quot  = (neg_a ^ neg_b) ? -q_mag : q_mag;
    rem   = neg_a ? -r_mag : r_mag;

    result = acc;
    unique case (op_q)
      OP_MULT, OP_MULTU: result = prod;
      OP_MADD, OP_MADDU: result = acc + prod;
      OP_MSUB, OP_MSUBU: result = acc - prod;
      OP_DIV, OP_DIVU:   result = (b_q == '0) ? acc : {rem, quot};
      default:           result = acc;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          unique case (op_i)
            OP_MTHI: hi_d = src_a_i;
            OP_MTLO: lo_d = src_a_i;
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU,
            OP_DIV, OP_DIVU: begin
              a_d     = src_a_i;
              b_d     = src_b_i;
              op_d    = op_i;
              state_d = ST_BUSY;
              cnt_d   = ((op_i == OP_DIV) || (op_i == OP_DIVU)) ? DivLatC : MulLatC;
            end
            default: ;
          endcase
        end
      end
      default: begin
        if (cnt_q <= CNT_W'(1)) begin
          {hi_d, lo_d} = result;
          state_d      = ST_IDLE;
          cnt_d        = '0;
          done_d       = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
    end
  end

  assign busy_o = (state_q == ST_BUSY);
  assign done_o = done_q;
  assign tnew_o = cnt_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Directed bench for muldiv_seq_unit: stimulus pushes expected HI/LO into a queue,
// a monitor pops and compares on every done pulse.
module tb_muldiv_seq_unit;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] src_a, src_b;
  logic             flush;
  logic             busy, done;
  logic [CNT_W-1:0] tnew;
  logic [WIDTH-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [2*WIDTH-1:0] exp_q[$];

  muldiv_seq_unit #(
    .WIDTH  (WIDTH),
    .MUL_LAT(5),
    .DIV_LAT(10)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start_i(start),
    .op_i   (op),
    .src_a_i(src_a),
    .src_b_i(src_b),
    .flush_i(flush),
    .busy_o (busy),
    .done_o (done),
    .tnew_o (tnew),
    .hi_o   (hi),
    .lo_o   (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got hi=%h lo=%h expected no done", hi, lo);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({hi, lo} !== e) begin
          errors++;
          $display("FAIL result: got %h_%h expected %h", hi, lo, e);
        end
      end
    end
  end

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic fl);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b; flush = fl;
    @(negedge clk);
    start = 1'b0; op = 4'd0; flush = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    for (n = 0; n < 40; n++) begin
      if (done) break;
      @(negedge clk);
    end
    if (n == 40) begin
      checks++;
      errors++;
      $display("FAIL %s: got no done within 40 cycles expected done", name);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 4'd0; src_a = '0; src_b = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_state", {busy, done, tnew, hi, lo}, '0);

    // mult -3 * 5: tnew counts 5..0, busy for exactly 5 cycles, one-cycle done
    exp_q.push_back(64'hFFFFFFFF_FFFFFFF1);
    issue(4'd1, 32'hFFFFFFFD, 32'd5, 1'b0);
    check("mult_tnew5", {busy, tnew}, {1'b1, 4'd5});
    for (int k = 4; k >= 0; k--) begin
      @(negedge clk);
      check($sformatf("mult_tnew%0d", k), {busy, tnew}, {(k != 0), 4'(k)});
    end
    check("mult_done_high", done, 1'b1);
    @(negedge clk);
    check("mult_done_low", done, 1'b0);

    exp_q.push_back({32'd1, 32'd3});
    issue(4'd4, 32'd7, 32'd2, 1'b0);
    wait_done("divu");
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
    issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_done("div_neg");

    issue(4'd9, 32'h0000AAAA, 32'd0, 1'b0);
    check("mthi", hi, 32'h0000AAAA);
    issue(4'd10, 32'h00005555, 32'd0, 1'b0);
    check("mtlo", lo, 32'h00005555);
    exp_q.push_back({32'h0000AAAA, 32'h00005555});
    issue(4'd3, 32'd123, 32'd0, 1'b0);
    wait_done("div_zero");
    exp_q.push_back({32'd0, 32'h80000000});
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_done("div_ovf");

    issue(4'd9, 32'd1, 32'd0, 1'b0);
    issue(4'd10, 32'hFFFFFFFF, 32'd0, 1'b0);
    exp_q.push_back({32'd2, 32'd0});
    issue(4'd6, 32'd1, 32'd1, 1'b0);
    wait_done("maddu");
    exp_q.push_back({32'd1, 32'hFFFFFFFE});
    issue(4'd7, 32'd1, 32'd2, 1'b0);
    wait_done("msub");

    // mtlo while busy must be dropped
    exp_q.push_back({32'd0, 32'd12});
    issue(4'd1, 32'd3, 32'd4, 1'b0);
    issue(4'd10, 32'h1234, 32'd0, 1'b0);
    wait_done("mult_ignore");
    @(negedge clk);
    check("mtlo_ignored", lo, 32'd12);

    issue(4'd1, 32'd9, 32'd9, 1'b1);
    check("flush_issue", {busy, tnew}, '0);

    exp_q.push_back({32'd0, 32'd42});
    issue(4'd1, 32'd7, 32'd6, 1'b0);
    flush = 1'b1;
    repeat (2) @(negedge clk);
    flush = 1'b0;
    wait_done("flush_busy");

    // reset mid-divide discards the op with no done pulse
    issue(4'd3, 32'd100, 32'd7, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_mid", {busy, done, tnew, hi, lo}, '0);
    repeat (15) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
